mem_io_ctrl: RTL and testbench
==============================

// Module: mem_io_ctrl
// PURPOSE
// - Data-side stage downstream of the single-cycle CPU: consumes Addres/WriteData/MemWrite, returns readData same cycle.
// - Decodes address into word RAM or MMIO window: output FIFO (valid/ready to a peripheral), status reg, free-running timer.
// - Sequential state: RAM array, FIFO pointers/count, timer, sticky error/overflow flags.
// PARAMETERS
// - RAM_WORDS   256           data RAM depth in 32-bit words (power of 2)
// - FIFO_DEPTH  8             output FIFO entries (power of 2, >=2)
// - IO_BASE     32'h0000_1000 MMIO window base; window = IO_BASE..IO_BASE+0xF
// PORTS
// - clk        in   1   clock, all state updates on rising edge
// - rst        in   1   synchronous, active-high reset
// - addr       in   32  byte address from CPU (Addres)
// - wdata      in   32  store data from CPU (WriteData)
// - we         in   1   store strobe from CPU (MemWrite)
// - rdata      out  32  load data to CPU (readData), combinational from addr
// - out_data   out  32  FIFO head word to peripheral
// - out_valid  out  1   FIFO non-empty
// - out_ready  in   1   peripheral accepts head this cycle
// - bus_err    out  1   sticky: store to unmapped address
// BEHAVIOUR
// - Decode: RAM hit if addr < RAM_WORDS*4; MMIO hit if addr[31:4]==IO_BASE[31:4]; else unmapped. addr[1:0] ignored.
// - MMIO map: +0x0 OUT (W push, R=0); +0x4 STATUS; +0x8 TIMER; +0xC reserved (R=0, W ignored, no err).
// - STATUS read: bit0 full, bit1 empty, bit2 ovf (sticky), bits[15:8] count, rest 0. Store with wdata[2]=1 clears ovf.
// - Reads: zero latency, combinational; unmapped reads return 0, no error. RAM read reflects contents before same-cycle store.
// - RAM store: we && RAM hit -> mem[addr[log2(RAM_WORDS)+1:2]] <= wdata at edge. RAM not cleared by rst.
// - FIFO push: we && OUT hit. Full and no pop -> word dropped, ovf<=1. Full with pop same cycle -> push accepted, count unchanged.
// - FIFO pop: out_valid && out_ready; head advances next edge. out_data stable while out_valid && !out_ready.
// - No bypass: push into empty FIFO -> out_valid high the following cycle (1-cycle latency).
// - Pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH, full = (count==FIFO_DEPTH).
// - Timer: +1 every cycle, wraps 0xFFFF_FFFF -> 0. Store to TIMER loads wdata (load beats increment); next cycle reads wdata, then wdata+1.
// - bus_err: set on we to unmapped address; cleared only by rst.
// - Reset (rst=1 at edge): count=0, pointers=0, out_valid=0, ovf=0, bus_err=0, timer=0; rst overrides any same-cycle store/pop.
// - Reset mid-transfer: FIFO contents discarded; out_valid low the cycle after rst sampled.
// CONFIGURATION
// - MMIO_TIMER_EN defined: timer present as above.
// - MMIO_TIMER_EN undefined: no timer logic; +0x8 reads 0, stores ignored, bus_err not set.
// TESTING
// - rst 1 cycle -> out_valid=0, bus_err=0, STATUS read = 32'h0000_0002, TIMER read = 0.
// - store 0xDEADBEEF @0x10, then load @0x10 -> 0xDEADBEEF; load @0x11 -> 0xDEADBEEF (byte bits ignored).
// - push 9 words (out_ready=0, depth 8) -> STATUS=0x0000_0805 (count 8, full, ovf); store STATUS wdata=4 -> ovf clears.
// - full FIFO, push 0x55 with out_ready=1 same cycle -> head popped, 0x55 accepted, count stays 8, last-popped order preserved.
// - store 0xFFFF_FFFE to TIMER -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0 on next three cycles.
// - store to 0x8000_0000 -> bus_err=1 next cycle, RAM/FIFO unchanged; load there -> 0; only rst clears bus_err.

Source files
------------

// File: rtl/mem_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_ctrl
// Purpose  : Data-side memory/IO stage for a single-cycle CPU. Decodes the
//            CPU byte address into a word RAM or a 16-byte MMIO window that
//            holds an output FIFO (valid/ready to a peripheral), a status
//            register and an optional free-running timer. Loads return data
//            combinationally in the same cycle; stores take effect at the
//            rising edge.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            addr/wdata/we    - CPU byte address, store data, store strobe
//            rdata            - CPU load data (combinational from addr)
//            out_data/out_valid/out_ready - FIFO head to peripheral
//            bus_err          - sticky flag: store to an unmapped address
// Config   : MMIO_TIMER_EN    - when defined, the timer at +0x8 is built;
//                               otherwise +0x8 reads 0 and ignores stores.
// Revision : 1.0 - initial release
// ============================================================================
module mem_io_ctrl #(
  parameter int          RAM_WORDS  = 256,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        bus_err
);

  localparam int          AW        = $clog2(RAM_WORDS);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  localparam logic [1:0] REG_OUT    = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_TIMER  = 2'd2;

  // Storage arrays (never reset)
  logic [31:0] ram_q  [RAM_WORDS];
  logic [31:0] fifo_q [FIFO_DEPTH];

  // Control state
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          ovf_q,    ovf_d;
  logic          bus_err_q, bus_err_d;

  // Address decode; RAM takes priority should the windows ever overlap
  logic          ram_hit, io_hit, unmapped;
  logic [1:0]    reg_sel;
  logic [AW-1:0] ram_idx;

  assign ram_hit  = (addr < RAM_BYTES);
  assign io_hit   = !ram_hit && (addr[31:4] == IO_BASE[31:4]);
  assign unmapped = !ram_hit && !io_hit;
  assign reg_sel  = addr[3:2];
  assign ram_idx  = addr[AW+1:2];

  // FIFO handshake
  logic full, empty, pop, push_req, push_ok, ovf_clr;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = !empty && out_ready;
  assign push_req = we && io_hit && (reg_sel == REG_OUT);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);
  assign ovf_clr  = we && io_hit && (reg_sel == REG_STATUS) && wdata[2];

  assign out_valid = !empty;
  assign out_data  = fifo_q[rd_ptr_q];
  assign bus_err   = bus_err_q;

  // Timer (optional)
  logic [31:0] timer_rd;

`ifdef MMIO_TIMER_EN
  logic [31:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q + 32'd1;
    // A store loads the timer and beats that cycle's increment.
    if (we && io_hit && (reg_sel == REG_TIMER)) begin
      timer_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign timer_rd = timer_q;
`else
  assign timer_rd = '0;
`endif

  // Next-state for FIFO bookkeeping and sticky flags
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    bus_err_d = bus_err_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end

    if (we && unmapped) begin
      bus_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Array writes; reset blocks stores but leaves the contents intact.
  always_ff @(posedge clk) begin
    if (!rst && we && ram_hit) begin
      ram_q[ram_idx] <= wdata;
    end
    if (!rst && push_ok) begin
      fifo_q[wr_ptr_q] <= wdata;
    end
  end

  // Load path: combinational, RAM shows contents before a same-cycle store
  logic [31:0] status_word;

  assign status_word = {16'd0, 8'(count_q), 5'd0, ovf_q, empty, full};

  always_comb begin
    rdata = '0;
    if (ram_hit) begin
      rdata = ram_q[ram_idx];
    end else if (io_hit) begin
      case (reg_sel)
        REG_STATUS: rdata = status_word;
        REG_TIMER:  rdata = timer_rd;
        default:    rdata = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_io_ctrl
// Purpose  : Self-checking bench for mem_io_ctrl. A queue holds the words the
//            FIFO should emit; every cycle the head/valid are compared before
//            the queue is updated with that cycle's push/pop.
// Config   : MMIO_TIMER_EN selects timer-present or timer-absent checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_io_ctrl;

  localparam logic [31:0] OUT_A = 32'h0000_1000;
  localparam logic [31:0] ST_A  = 32'h0000_1004;
  localparam logic [31:0] TM_A  = 32'h0000_1008;
  localparam logic [31:0] RS_A  = 32'h0000_100C;
  localparam logic [31:0] BAD_A = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata, out_data;
  logic        we, out_valid, out_ready, bus_err;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_io_ctrl #(
    .RAM_WORDS (256),
    .FIFO_DEPTH(8),
    .IO_BASE   (32'h0000_1000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .rdata    (rdata),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bus_err  (bus_err)
  );

  // Compare FIFO outputs against the queue head, then apply this cycle's
  // pop and push to the queue (no bypass: a push shows up a cycle later).
  task automatic monitor();
    logic exp_valid;
    exp_valid = (exp_q.size() != 0);
    if (rst) begin
      exp_q.delete();
      return;
    end
    checks++;
    if (out_valid !== exp_valid) begin
      failures++;
      $display("FAIL out_valid got=%b exp=%b", out_valid, exp_valid);
    end
    if (exp_valid) begin
      checks++;
      if (out_data !== exp_q[0]) begin
        failures++;
        $display("FAIL out_data got=%h exp=%h", out_data, exp_q[0]);
      end
    end
    if (exp_valid && out_ready) void'(exp_q.pop_front());
    if (we && addr == OUT_A && exp_q.size() < 8) exp_q.push_back(wdata);
  endtask

  // One clock: check at the falling edge, return 1ns after the rising edge.
  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a);
    we   = 1'b0;
    addr = a;
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) cyc();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got=%0d exp=0", exp_q.size());
    end
    out_ready = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; out_ready = 1'b0; addr = '0; wdata = '0;
    cyc(); cyc();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || bus_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b%b exp=00", out_valid, bus_err);
    end
    rd(TM_A);
    checks++;
    if (rdata !== 32'h0) begin
      failures++; $display("FAIL reset_timer got=%h exp=%h", rdata, 32'h0);
    end
    rd(ST_A);
    checks++;
    if (rdata !== 32'h0000_0002) begin
      failures++; $display("FAIL reset_status got=%h exp=%h", rdata, 32'h2);
    end
  endtask

  task automatic test_ram();
    we = 1'b1; addr = 32'h10; wdata = 32'hDEAD_BEEF;
    cyc();
    rd(32'h10);
    checks++;
    if (rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL ram_10 got=%h exp=%h", rdata, 32'hDEAD_BEEF);
    end
    rd(32'h11);
    checks++;
    if (rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL ram_11 got=%h exp=%h", rdata, 32'hDEAD_BEEF);
    end
    // Same-cycle store must not be visible on the load path yet.
    we = 1'b1; addr = 32'h10; wdata = 32'h1234_5678;
    #1;
    checks++;
    if (rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL ram_rbw got=%h exp=%h", rdata, 32'hDEAD_BEEF);
    end
    cyc();
    rd(32'h10);
    checks++;
    if (rdata !== 32'h1234_5678) begin
      failures++; $display("FAIL ram_new got=%h exp=%h", rdata, 32'h1234_5678);
    end
    we = 1'b1; addr = 32'h3FC; wdata = 32'hCAFE_F00D;
    cyc();
    rd(32'h3FC);
    checks++;
    if (rdata !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL ram_top got=%h exp=%h", rdata, 32'hCAFE_F00D);
    end
    rd(32'h400);
    checks++;
    if (rdata !== 32'h0 || bus_err !== 1'b0) begin
      failures++; $display("FAIL unmapped_rd got=%h/%b exp=0/0", rdata, bus_err);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      we = 1'b1; addr = OUT_A; wdata = 32'h100 + 32'(i);
      cyc();
    end
    rd(ST_A);
    checks++;
    if (rdata !== 32'h0000_0805) begin
      failures++; $display("FAIL status_ovf got=%h exp=%h", rdata, 32'h805);
    end
    rd(OUT_A);
    checks++;
    if (rdata !== 32'h0) begin
      failures++; $display("FAIL out_read got=%h exp=%h", rdata, 32'h0);
    end
    we = 1'b1; addr = ST_A; wdata = 32'h4;
    cyc();
    rd(ST_A);
    checks++;
    if (rdata !== 32'h0000_0801) begin
      failures++; $display("FAIL ovf_clear got=%h exp=%h", rdata, 32'h801);
    end
  endtask

  task automatic test_full_push_pop();
    we = 1'b1; addr = OUT_A; wdata = 32'h55; out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    rd(ST_A);
    checks++;
    if (rdata !== 32'h0000_0801) begin
      failures++; $display("FAIL full_pushpop got=%h exp=%h", rdata, 32'h801);
    end
    cyc(); cyc();   // head must hold while out_ready is low
    drain();
    rd(ST_A);
    checks++;
    if (rdata !== 32'h0000_0002) begin
      failures++; $display("FAIL drained got=%h exp=%h", rdata, 32'h2);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      we = 1'b1; addr = OUT_A; wdata = $urandom;
      cyc();
    end
    we = 1'b0;
    drain();
  endtask

  task automatic test_timer();
`ifdef MMIO_TIMER_EN
    logic [31:0] exp_t[4];
    exp_t[0] = 32'hFFFF_FFFE; exp_t[1] = 32'hFFFF_FFFF;
    exp_t[2] = 32'h0;         exp_t[3] = 32'h1;
    we = 1'b1; addr = TM_A; wdata = 32'hFFFF_FFFE;
    cyc();
    for (int i = 0; i < 4; i++) begin
      rd(TM_A);
      checks++;
      if (rdata !== exp_t[i]) begin
        failures++; $display("FAIL timer_%0d got=%h exp=%h", i, rdata, exp_t[i]);
      end
      cyc();
    end
`else
    we = 1'b1; addr = TM_A; wdata = 32'h1234;
    cyc();
    rd(TM_A);
    checks++;
    if (rdata !== 32'h0 || bus_err !== 1'b0) begin
      failures++; $display("FAIL no_timer got=%h/%b exp=0/0", rdata, bus_err);
    end
`endif
    we = 1'b1; addr = RS_A; wdata = 32'hFFFF;
    cyc();
    rd(RS_A);
    checks++;
    if (rdata !== 32'h0 || bus_err !== 1'b0) begin
      failures++; $display("FAIL reserved got=%h/%b exp=0/0", rdata, bus_err);
    end
  endtask

  task automatic test_bus_err();
    we = 1'b1; addr = BAD_A; wdata = 32'hAAAA_5555;
    cyc();
    we = 1'b0;
    checks++;
    if (bus_err !== 1'b1) begin
      failures++; $display("FAIL bus_err_set got=%b exp=1", bus_err);
    end
    rd(BAD_A);
    checks++;
    if (rdata !== 32'h0) begin
      failures++; $display("FAIL bad_read got=%h exp=%h", rdata, 32'h0);
    end
    rd(32'h10);
    checks++;
    if (rdata !== 32'h1234_5678) begin
      failures++; $display("FAIL ram_kept got=%h exp=%h", rdata, 32'h1234_5678);
    end
    cyc(); cyc(); cyc();
    rd(ST_A);
    checks++;
    if (bus_err !== 1'b1 || rdata !== 32'h2) begin
      failures++; $display("FAIL bus_err_sticky got=%b/%h exp=1/2", bus_err, rdata);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      we = 1'b1; addr = OUT_A; wdata = 32'hA0 + 32'(i);
      cyc();
    end
    rst = 1'b1; we = 1'b1; addr = OUT_A; wdata = 32'hBB; out_ready = 1'b1;
    cyc();
    rst = 1'b0; out_ready = 1'b0;
    rd(ST_A);
    checks++;
    if (out_valid !== 1'b0 || bus_err !== 1'b0 || rdata !== 32'h2) begin
      failures++;
      $display("FAIL reset_mid got=%b/%b/%h exp=0/0/2", out_valid, bus_err, rdata);
    end
    rd(32'h10);
    checks++;
    if (rdata !== 32'h1234_5678) begin
      failures++; $display("FAIL ram_after_rst got=%h exp=%h", rdata, 32'h1234_5678);
    end
    cyc(); cyc();
  endtask

  initial begin
    test_reset();
    test_ram();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_timer();
    test_bus_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
